alu_seq: RTL and testbench

- Parametrised, registered successor to the 2-bit-opcode combinational ALU. Generalised to WIDTH-bit data and a 3-bit opcode.
- Adds persistent flags, which enables multi-word ADC/SBB chaining.
- Adds multi-cycle bit-serial shifts and a valid/ready handshake on both the command side and the result side.
- Sits between the register file and writeback/PC logic. Branch and toggle decisions are issued alongside each result.

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with persistent carry/borrow/zero flags, bit-serial shifts and
// valid/ready handshakes on the command and result sides.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] addrs,
    input  logic [WIDTH-1:0]  d_in0,
    input  logic [WIDTH-1:0]  d_in1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  d_out,
    output logic              carry,
    output logic              borrow,
    output logic              zero,
    output logic              bcf,
    output logic              bbf,
    output logic              buc,
    output logic              toggle_out,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_MOV = 3'b011;
    localparam logic [2:0] OP_ADC = 3'b100;
    localparam logic [2:0] OP_SBB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

    localparam logic [ADDR_W-1:0] A_TGL = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] A_BUC = A_TGL - ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_BBF = A_TGL - ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_BCF = A_TGL - ADDR_W'(3);

    logic [0:0]         state;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   sh_reg;
    logic               sh_left;
    logic               bcf_r, bbf_r, buc_r;

    logic               accept, is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic               cin, bin;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   res;
    logic               nxt_carry, nxt_borrow, nxt_zero, upd_zero;
    logic               n_bcf, n_bbf, n_buc, n_tgl;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_bit;

    // A command transfers on a clock edge where in_valid && in_ready; a result
    // transfers on an edge where out_valid && out_ready. Both may happen on one edge.
    assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_SHIFT);
    assign is_shift = (opcode[2:1] == 2'b11);
    assign shamt    = d_in1[SHAMT_W-1:0];

    assign bcf = bcf_r && out_valid;
    assign bbf = bbf_r && out_valid;
    assign buc = buc_r && out_valid;

    assign sh_next = sh_left ? {sh_reg[WIDTH-2:0], 1'b0} : {1'b0, sh_reg[WIDTH-1:1]};
    assign sh_bit  = sh_left ? sh_reg[WIDTH-1] : sh_reg[0];

    always_comb begin
        // opcode[2] separates ADC/SBB from ADD/SUB, so it gates the incoming flag
        cin        = opcode[2] & carry;
        bin        = opcode[2] & borrow;
        sum        = {1'b0, d_in0} + {1'b0, d_in1} + {{WIDTH{1'b0}}, cin};
        diff       = {1'b0, d_in0} - {1'b0, d_in1} - {{WIDTH{1'b0}}, bin};
        res        = d_in0;
        nxt_carry  = carry;
        nxt_borrow = borrow;
        upd_zero   = 1'b1;
        n_bcf      = 1'b0;
        n_bbf      = 1'b0;
        n_buc      = 1'b0;
        n_tgl      = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                res       = sum[WIDTH-1:0];
                nxt_carry = sum[WIDTH];
            end
            OP_SUB, OP_SBB: begin
                res        = diff[WIDTH-1:0];
                nxt_borrow = diff[WIDTH];
            end
            OP_XOR: res = d_in0 ^ d_in1;
            OP_MOV: begin
                upd_zero = 1'b0;
                n_bcf    = (addrs == A_BCF) && carry;
                n_bbf    = (addrs == A_BBF) && borrow;
                n_buc    = (addrs == A_BUC);
                n_tgl    = (addrs == A_TGL);
            end
            default: ; // zero-amount shift: operand passes through, carry held
        endcase
        nxt_zero = upd_zero ? (res == '0) : zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sh_reg     <= '0;
            sh_left    <= 1'b0;
            out_valid  <= 1'b0;
            d_out      <= '0;
            carry      <= 1'b0;
            borrow     <= 1'b0;
            zero       <= 1'b0;
            bcf_r      <= 1'b0;
            bbf_r      <= 1'b0;
            buc_r      <= 1'b0;
            toggle_out <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_shift && shamt != '0) begin
                            sh_reg  <= d_in0;
                            sh_left <= (opcode == OP_SHL);
                            cnt     <= shamt;
                            state   <= ST_SHIFT;
                        end else begin
                            d_out     <= res;
                            carry     <= nxt_carry;
                            borrow    <= nxt_borrow;
                            zero      <= nxt_zero;
                            bcf_r     <= n_bcf;
                            bbf_r     <= n_bbf;
                            buc_r     <= n_buc;
                            out_valid <= 1'b1;
                            if (n_tgl)
                                toggle_out <= ~toggle_out;
                        end
                    end
                end
                default: begin
                    sh_reg <= sh_next;
                    cnt    <= cnt - SHAMT_W'(1);
                    // last step: the bit leaving now becomes the carry
                    if (cnt == SHAMT_W'(1)) begin
                        d_out     <= sh_next;
                        carry     <= sh_bit;
                        zero      <= (sh_next == '0);
                        bcf_r     <= 1'b0;
                        bbf_r     <= 1'b0;
                        buc_r     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: stimulus pushes hand-computed results,
// a forked monitor pops and compares each consumed result.
module tb_alu_seq;
    localparam int W  = 8;
    localparam int AW = 4;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b010, MOV = 3'b011;
    localparam logic [2:0] ADC = 3'b100, SBB = 3'b101, SHL = 3'b110, SHR = 3'b111;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    opcode;
    logic [AW-1:0] addrs;
    logic [W-1:0]  d_in0, d_in1, d_out;
    logic          carry, borrow, zero, bcf, bbf, buc, toggle_out, busy;

    logic [W+6:0]  exp_q[$];
    int            n_vec = 0;
    int            n_miss = 0;

    alu_seq #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .addrs(addrs), .d_in0(d_in0), .d_in1(d_in1),
        .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
        .carry(carry), .borrow(borrow), .zero(zero), .bcf(bcf), .bbf(bbf),
        .buc(buc), .toggle_out(toggle_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W+6:0] pk(input logic [W-1:0] d, input logic c, b, z,
                                        input logic f_c, f_b, f_u, t);
        return {d, c, b, z, f_c, f_b, f_u, t};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 right after the accepting edge.
    task automatic issue(input string name, input logic [2:0] op, input logic [AW-1:0] ad,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W+6:0] e);
        int waited;
        waited   = 0;
        opcode   = op;
        addrs    = ad;
        d_in0    = a;
        d_in1    = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #3;
            waited++;
        end
        check({name, "_accept"}, 32'(in_ready), 32'd1);
        if (in_ready) begin
            if (push) exp_q.push_back(e);
            @(posedge clk);
            #2;
        end else begin
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            step();
            w++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int ov;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; addrs = '0; d_in0 = '0; d_in1 = '0;

        fork
            begin
                logic [W+6:0] e;
                forever begin
                    @(negedge clk);
                    if (!rst && out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("result", 32'({d_out, carry, borrow, zero, bcf, bbf, buc, toggle_out}),
                                  32'(e));
                        end
                    end
                end
            end
        join_none

        // reset state
        step();
        check("in_ready_during_rst", 32'(in_ready), 32'd0);
        step();
        check("reset_outputs", 32'({out_valid, busy, d_out, carry, borrow, zero, bcf, bbf, buc, toggle_out}), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        step();

        // reset in the middle of a 5-step shift
        issue("shl5_abort", SHL, 4'h0, 8'h81, 8'h05, 1'b0, '0);
        check("abort_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_outputs", 32'({out_valid, busy, d_out, carry, borrow, zero, bcf, bbf, buc, toggle_out}), 32'd0);
        ov = 0;
        repeat (8) begin
            step();
            ov += int'(out_valid);
        end
        check("abort_no_result", 32'(ov), 32'd0);

        // carry chaining
        issue("add_f0_20", ADD, 4'h0, 8'hF0, 8'h20, 1'b1, pk(8'h10, 1, 0, 0, 0, 0, 0, 0));
        check("add_latency", 32'(out_valid), 32'd1);
        issue("adc_01_00", ADC, 4'h0, 8'h01, 8'h00, 1'b1, pk(8'h02, 0, 0, 0, 0, 0, 0, 0));
        issue("xor_5a_5a", XOR, 4'h0, 8'h5A, 8'h5A, 1'b1, pk(8'h00, 0, 0, 1, 0, 0, 0, 0));

        // borrow chaining
        issue("sub_05_06", SUB, 4'h0, 8'h05, 8'h06, 1'b1, pk(8'hFF, 0, 1, 0, 0, 0, 0, 0));
        issue("sbb_10_00", SBB, 4'h0, 8'h10, 8'h00, 1'b1, pk(8'h0F, 0, 0, 0, 0, 0, 0, 0));
        issue("sub_00_01", SUB, 4'h0, 8'h00, 8'h01, 1'b1, pk(8'hFF, 0, 1, 0, 0, 0, 0, 0));
        issue("sbb_00_00", SBB, 4'h0, 8'h00, 8'h00, 1'b1, pk(8'hFF, 0, 1, 0, 0, 0, 0, 0));
        issue("add_ff_01", ADD, 4'h0, 8'hFF, 8'h01, 1'b1, pk(8'h00, 1, 1, 1, 0, 0, 0, 0));

        // shift timing
        issue("shl_81_3", SHL, 4'h0, 8'h81, 8'h03, 1'b1, pk(8'h08, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            check("shift_busy_window", 32'({busy, in_ready, out_valid}), 32'b100);
            step();
        end
        check("shift_done", 32'({busy, in_ready, out_valid}), 32'b011);
        issue("shr_81_1", SHR, 4'h0, 8'h81, 8'h01, 1'b1, pk(8'h40, 1, 1, 0, 0, 0, 0, 0));
        check("shr1_busy", 32'(busy), 32'd1);
        issue("shl_3c_0", SHL, 4'h0, 8'h3C, 8'h08, 1'b1, pk(8'h3C, 1, 1, 0, 0, 0, 0, 0));
        check("shl0_latency", 32'({busy, out_valid}), 32'b01);
        issue("shr_80_7", SHR, 4'h0, 8'h80, 8'h07, 1'b1, pk(8'h01, 0, 1, 0, 0, 0, 0, 0));
        drain();

        // backpressure, then same-edge consume and accept
        out_ready = 1'b0;
        issue("add_01_01", ADD, 4'h0, 8'h01, 8'h01, 1'b1, pk(8'h02, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            check("hold_state", 32'({out_valid, in_ready, d_out}), 32'({1'b1, 1'b0, 8'h02}));
            step();
        end
        out_ready = 1'b1;
        issue("xor_0f_f0", XOR, 4'h0, 8'h0F, 8'hF0, 1'b1, pk(8'hFF, 0, 1, 0, 0, 0, 0, 0));
        check("reload_after_consume", 32'({out_valid, d_out}), 32'({1'b1, 8'hFF}));

        // branch and toggle decode
        issue("add_80_80", ADD, 4'h0, 8'h80, 8'h80, 1'b1, pk(8'h00, 1, 1, 1, 0, 0, 0, 0));
        issue("mov_c", MOV, 4'hC, 8'h33, 8'h00, 1'b1, pk(8'h33, 1, 1, 1, 1, 0, 0, 0));
        issue("mov_d", MOV, 4'hD, 8'h34, 8'h00, 1'b1, pk(8'h34, 1, 1, 1, 0, 1, 0, 0));
        issue("mov_e", MOV, 4'hE, 8'h44, 8'h00, 1'b1, pk(8'h44, 1, 1, 1, 0, 0, 1, 0));
        issue("mov_f1", MOV, 4'hF, 8'h55, 8'h00, 1'b1, pk(8'h55, 1, 1, 1, 0, 0, 0, 1));
        issue("mov_f2", MOV, 4'hF, 8'h66, 8'h00, 1'b1, pk(8'h66, 1, 1, 1, 0, 0, 0, 0));
        issue("mov_3", MOV, 4'h3, 8'h77, 8'h00, 1'b1, pk(8'h77, 1, 1, 1, 0, 0, 0, 0));
        drain();
        step();
        check("idle_at_end", 32'({out_valid, busy, in_ready}), 32'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
